// File: rtl/pc_unit.sv
// MIPS program-counter stage: PC register plus next-PC select, with link, flush and misaligned outputs.
// Latency: a redirect sampled at edge N loads pc at edge N, and flush is high in cycle N+1. Stall holds pc and drops redirects.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               OFFSET_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_target,
  input  logic                jump_reg,
  input  logic [WIDTH-1:0]    reg_target,
  output logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    pc_plus_inc,
  output logic [WIDTH-1:0]    link,
  output logic                flush,
  output logic                misaligned
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [WIDTH-1:0] offset_ext;
  logic [WIDTH-1:0] branch_npc;
  logic [WIDTH-1:0] jump_npc;

  assign pc_plus_inc = pc_q + WIDTH'(INC);
  assign offset_ext  = WIDTH'($signed(branch_offset));
  assign branch_npc  = pc_plus_inc + (offset_ext << 2);

  // A 28-bit PC has no region bits above the jump field.
  generate
    if (WIDTH > 28) begin : g_jump_hi
      assign jump_npc = {pc_plus_inc[WIDTH-1:28], jump_target, 2'b00};
    end else begin : g_jump_lo
      assign jump_npc = {jump_target, 2'b00};
    end
  endgenerate

  always_comb begin
    pc_d    = pc_q;
    flush_d = 1'b0;
    if (!stall) begin
      if (jump_reg) begin
        pc_d    = reg_target;
        flush_d = 1'b1;
      end else if (jump) begin
        pc_d    = jump_npc;
        flush_d = 1'b1;
      end else if (branch_taken) begin
        pc_d    = branch_npc;
        flush_d = 1'b1;
      end else begin
        pc_d    = pc_plus_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign pc         = pc_q;
  assign link       = pc_plus_inc;
  assign flush      = flush_q;
  assign misaligned = |pc_q[1:0];

endmodule
